// File: rtl/rv32i_pkg.sv
// Shared types and widths for the RV32I memory arbiter.
package rv32i_pkg;

    localparam int XLEN = 32;

    // Arbiter transaction state: one request in flight at most.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } state_e;

    // Which requester owns the current transaction.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/rv32i_arb_prio.sv
// Winner selection between fetch and data ports with fetch anti-starvation.
// Data normally wins; once data has won STARVE_LIMIT times in a row while
// fetch was waiting, fetch is given the next slot.
module rv32i_arb_prio
    import rv32i_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   arb_en_i,
    input  logic   if_valid_i,
    input  logic   dm_valid_i,
    output owner_e winner_o
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Fetch wins when it is alone, or when data has starved it long enough.
    always_comb begin
        winner_o = OWN_DM;
        if (if_valid_i && (!dm_valid_i || (starve_cnt == CNT_MAX))) begin
            winner_o = OWN_IF;
        end
    end

    // Count data wins that happen while fetch is waiting; saturate at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (arb_en_i) begin
            if ((winner_o == OWN_DM) && if_valid_i) begin
                if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single shared memory port.
// One transaction outstanding: IDLE -> WAIT_GNT -> WAIT_RSP -> RESP -> IDLE.
// A response that never arrives is closed with err=1 after TIMEOUT_CYCLES.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_rsp_valid_o,
    output logic            if_rsp_err_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            dm_valid_i,
    output logic            dm_ready_o,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic            dm_we_i,
    input  logic [3:0]      dm_be_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_rsp_valid_o,
    output logic            dm_rsp_err_o,
    output logic [XLEN-1:0] dm_rdata_o,

    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    owner_e          owner_q;
    owner_e          winner;
    logic            arb_en;
    logic            tmo_last;
    logic [TMO_W-1:0] tmo_q;

    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    assign arb_en   = (state_q == IDLE) && (if_valid_i || dm_valid_i);
    assign tmo_last = (tmo_q == TMO_LAST);

    rv32i_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_prio (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .arb_en_i   (arb_en),
        .if_valid_i (if_valid_i),
        .dm_valid_i (dm_valid_i),
        .winner_o   (winner)
    );

    // State register; reset abandons whatever was in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/response outputs.
    always_comb begin
        state_d        = state_q;
        if_ready_o     = 1'b0;
        dm_ready_o     = 1'b0;
        mem_req_o      = 1'b0;
        if_rsp_valid_o = 1'b0;
        dm_rsp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready is gated by reset so nothing is accepted while held in reset.
                if (arb_en && rst_ni) begin
                    if_ready_o = (winner == OWN_IF);
                    dm_ready_o = (winner == OWN_DM);
                    state_d    = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid_i || tmo_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if_rsp_valid_o = (owner_q == OWN_IF);
                dm_rsp_valid_o = (owner_q == OWN_DM);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response data is only visible to the owner during its response cycle.
    assign if_rdata_o   = if_rsp_valid_o ? rdata_q : '0;
    assign if_rsp_err_o = if_rsp_valid_o & err_q;
    assign dm_rdata_o   = dm_rsp_valid_o ? rdata_q : '0;
    assign dm_rsp_err_o = dm_rsp_valid_o & err_q;

    // Latch the winning request; fetches are always full-word reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= '0;
        end else if (arb_en) begin
            owner_q <= winner;
            if (winner == OWN_IF) begin
                addr_q  <= if_addr_i;
                we_q    <= 1'b0;
                be_q    <= 4'hF;
                wdata_q <= '0;
            end else begin
                addr_q  <= dm_addr_i;
                we_q    <= dm_we_i;
                be_q    <= dm_be_i;
                wdata_q <= dm_wdata_i;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

    // Cycles spent in WAIT_RSP; zero on entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (state_q == WAIT_RSP) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end

    // Capture the response; a real rvalid beats a timeout in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == WAIT_RSP) begin
            if (mem_rvalid_i) begin
                rdata_q <= we_q ? '0 : mem_rdata_i;
                err_q   <= 1'b0;
            end else if (tmo_last) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_valid, dm_ready, dm_we, dm_rsp_valid, dm_rsp_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32i_mem_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .if_valid_i     (if_valid),
        .if_ready_o     (if_ready),
        .if_addr_i      (if_addr),
        .if_rsp_valid_o (if_rsp_valid),
        .if_rsp_err_o   (if_rsp_err),
        .if_rdata_o     (if_rdata),
        .dm_valid_i     (dm_valid),
        .dm_ready_o     (dm_ready),
        .dm_addr_i      (dm_addr),
        .dm_we_i        (dm_we),
        .dm_be_i        (dm_be),
        .dm_wdata_i     (dm_wdata),
        .dm_rsp_valid_o (dm_rsp_valid),
        .dm_rsp_err_o   (dm_rsp_err),
        .dm_rdata_o     (dm_rdata),
        .mem_req_o      (mem_req),
        .mem_gnt_i      (mem_gnt),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_valid = 1'b1; if_addr = 32'h0;
        dm_valid = 1'b1; dm_addr = 32'h0; dm_we = 1'b0; dm_be = 4'h0; dm_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        settle(); settle();
        n_cmp++; if ({if_ready, dm_ready, mem_req} !== 3'b000) begin n_bad++; $display("FAIL reset_ready_req: got %b want 000", {if_ready, dm_ready, mem_req}); end
        n_cmp++; if ({if_rsp_valid, dm_rsp_valid, if_rsp_err, dm_rsp_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp: got %b want 0000", {if_rsp_valid, dm_rsp_valid, if_rsp_err, dm_rsp_err}); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_be !== 4'h0) begin n_bad++; $display("FAIL reset_fields: got addr %h be %h want 0 0", mem_addr, mem_be); end
        tick();
        rst_n = 1'b1; if_valid = 1'b0; dm_valid = 1'b0;
    endtask

    task automatic test_fetch_read();
        tick();
        if_valid = 1'b1; if_addr = 32'h0000_0010;
        settle();
        n_cmp++; if ({if_ready, dm_ready} !== 2'b10) begin n_bad++; $display("FAIL fetch_accept: got %b want 10", {if_ready, dm_ready}); end
        tick();
        if_valid = 1'b0; if_addr = 32'h0; mem_gnt = 1'b1;
        settle();
        n_cmp++; if ({mem_req, mem_we, mem_be} !== 6'b101111 || mem_addr !== 32'h10) begin n_bad++; $display("FAIL fetch_req: got req/we/be %b addr %h want 101111 00000010", {mem_req, mem_we, mem_be}, mem_addr); end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        n_cmp++; if (if_rsp_valid !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_early_rsp: got rsp %b req %b want 0 0", if_rsp_valid, mem_req); end
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        settle();
        n_cmp++; if (if_rsp_valid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || if_rsp_err !== 1'b0 || dm_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_rsp: got v %b d %h e %b dmv %b want 1 deadbeef 0 0", if_rsp_valid, if_rdata, if_rsp_err, dm_rsp_valid); end
        tick();
        settle();
        n_cmp++; if (if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_rsp_one_cycle: got %b want 0", if_rsp_valid); end
    endtask

    task automatic test_simultaneous();
        tick();
        if_valid = 1'b1; if_addr = 32'h100;
        dm_valid = 1'b1; dm_addr = 32'h200; dm_we = 1'b1; dm_be = 4'b0011; dm_wdata = 32'h1234;
        settle();
        n_cmp++; if ({if_ready, dm_ready} !== 2'b01) begin n_bad++; $display("FAIL sim_data_first: got if/dm %b want 01", {if_ready, dm_ready}); end
        tick();
        dm_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234) begin n_bad++; $display("FAIL sim_data_req: got req %b we %b be %b addr %h wd %h want 1 1 0011 200 1234", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
        n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL sim_loser_ready: got %b want 0", if_ready); end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b1 || dm_rdata !== 32'h0 || if_rsp_valid !== 1'b0 || if_ready !== 1'b0) begin n_bad++; $display("FAIL sim_write_rsp: got v %b d %h ifv %b ifr %b want 1 0 0 0", dm_rsp_valid, dm_rdata, if_rsp_valid, if_ready); end
        tick();
        settle();
        n_cmp++; if ({if_ready, dm_ready} !== 2'b10) begin n_bad++; $display("FAIL sim_fetch_next: got if/dm %b want 10", {if_ready, dm_ready}); end
        tick();
        if_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        n_cmp++; if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL sim_fetch_fields: got addr %h we %b be %h wd %h want 100 0 f 0", mem_addr, mem_we, mem_be, mem_wdata); end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_cmp++; if (if_rsp_valid !== 1'b1 || if_rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL sim_fetch_rsp: got v %b d %h want 1 cafe0001", if_rsp_valid, if_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        logic [5:0] seq;
        int k = 0;
        int cyc = 0;
        seq = 6'b0;
        tick();
        if_valid = 1'b1; if_addr = 32'h700;
        dm_valid = 1'b1; dm_addr = 32'h800; dm_we = 1'b0; dm_be = 4'hF;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1;
        while (k < 6 && cyc < 100) begin
            settle();
            if (dm_ready) begin seq[k] = 1'b0; k++; end
            else if (if_ready) begin seq[k] = 1'b1; k++; end
            cyc++;
            if (k < 6) tick();
        end
        n_cmp++; if (k != 6) begin n_bad++; $display("FAIL starve_budget: got %0d grants want 6", k); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (seq[i] !== (i == 4)) begin n_bad++; $display("FAIL starve_grant%0d: got fetch=%b want %b", i, seq[i], (i == 4)); end
        end
        tick();
        if_valid = 1'b0; dm_valid = 1'b0;
        repeat (4) tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout();
        int early = 0;
        tick();
        dm_valid = 1'b1; dm_addr = 32'h300; dm_we = 1'b0; dm_be = 4'hF;
        settle();
        n_cmp++; if (dm_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_accept: got %b want 1", dm_ready); end
        tick();
        dm_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (dm_rsp_valid !== 1'b0) early++;
            tick();
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL tmo_early: got %0d early responses want 0", early); end
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b1 || dm_rsp_err !== 1'b1 || dm_rdata !== 32'h0) begin n_bad++; $display("FAIL tmo_rsp: got v %b e %b d %h want 1 1 0", dm_rsp_valid, dm_rsp_err, dm_rdata); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL tmo_late_rvalid: got dmv %b ifv %b req %b want 0 0 0", dm_rsp_valid, if_rsp_valid, mem_req); end
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_late_rvalid2: got %b want 0", dm_rsp_valid); end
    endtask

    task automatic test_timeout_race();
        tick();
        dm_valid = 1'b1; dm_addr = 32'h340; dm_we = 1'b0; dm_be = 4'hF;
        tick();
        dm_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (7) tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_0007;
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b1 || dm_rsp_err !== 1'b0 || dm_rdata !== 32'h5A5A_0007) begin n_bad++; $display("FAIL race_rsp: got v %b e %b d %h want 1 0 5a5a0007", dm_rsp_valid, dm_rsp_err, dm_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        dm_valid = 1'b1; dm_addr = 32'h500; dm_we = 1'b0; dm_be = 4'hF;
        tick();
        dm_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        if_valid = 1'b1; dm_valid = 1'b1; rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_req, if_ready, dm_ready, if_rsp_valid, dm_rsp_valid} !== 5'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin n_bad++; $display("FAIL rst_mid_outputs: got ctl %b addr %h be %h want 00000 0 0", {mem_req, if_ready, dm_ready, if_rsp_valid, dm_rsp_valid}, mem_addr, mem_be); end
        tick(); tick();
        rst_n = 1'b1; if_valid = 1'b0; dm_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_late_rvalid: got dmv %b ifv %b want 0 0", dm_rsp_valid, if_rsp_valid); end
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_rsp: got %b want 0", dm_rsp_valid); end
        tick();
        dm_valid = 1'b1; dm_addr = 32'h600; dm_we = 1'b1; dm_be = 4'b1000; dm_wdata = 32'hAB00_0000;
        settle();
        n_cmp++; if (dm_ready !== 1'b1) begin n_bad++; $display("FAIL rst_new_accept: got %b want 1", dm_ready); end
        tick();
        dm_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b1 || mem_be !== 4'b1000) begin n_bad++; $display("FAIL rst_new_req: got req %b addr %h we %b be %b want 1 600 1 1000", mem_req, mem_addr, mem_we, mem_be); end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_cmp++; if (dm_rsp_valid !== 1'b1 || dm_rdata !== 32'h0 || dm_rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_new_rsp: got v %b d %h e %b want 1 0 0", dm_rsp_valid, dm_rdata, dm_rsp_err); end
        tick();
    endtask

    task automatic test_held_grant();
        int bad_req = 0;
        int bad_addr = 0;
        int bad_rdy = 0;
        tick();
        if_valid = 1'b1; if_addr = 32'h440;
        settle();
        n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL hold_accept: got %b want 1", if_ready); end
        tick();
        if_addr = 32'h444; dm_valid = 1'b1; dm_addr = 32'h999; dm_we = 1'b0; mem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (mem_req !== 1'b1) bad_req++;
            if (mem_addr !== 32'h440) bad_addr++;
            if (if_ready !== 1'b0 || dm_ready !== 1'b0) bad_rdy++;
            tick();
        end
        n_cmp++; if (bad_req != 0) begin n_bad++; $display("FAIL hold_req: got %0d cycles without req want 0", bad_req); end
        n_cmp++; if (bad_addr != 0) begin n_bad++; $display("FAIL hold_addr: got %0d cycles with wrong addr want 0", bad_addr); end
        n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL hold_ready: got %0d cycles with ready want 0", bad_rdy); end
        if_valid = 1'b0; dm_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0;
        settle();
        n_cmp++; if (if_rsp_valid !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL hold_rsp: got v %b d %h want 1 0badf00d", if_rsp_valid, if_rdata); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        test_held_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
